// File: rtl/mul_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// mul_hilo_ctrl
//
// Purpose:
//   Sequencing and result-holding stage behind the combinational bit-pair
//   Booth multiplier of the Mini SRC datapath. The block registers the two
//   operands that feed the multiplier and holds them stable for a LATENCY-cycle
//   multicycle window. It then captures the 64-bit product into the
//   architectural HI/LO pair. It also serves mfhi/mflo/mthi/mtlo traffic and
//   stalls the pipeline while a multiply is in flight.
//
// Parameters:
//   LATENCY   cycles granted to the multiplier's combinational path (>= 1)
//
// Optional feature (compile-time macro):
//   MUL_HILO_ZERO_SKIP_EN
//     When defined, a start with a zero operand completes at once. HI/LO are
//     cleared and done pulses in the next cycle, and the FSM never enters WAIT.
//
// Ports:
//   clock     in   1   system clock, rising edge
//   clear_n   in   1   asynchronous active-low reset
//   start     in   1   begin multiply of op_x * op_y
//   op_x      in  32   multiplicand (two's complement)
//   op_y      in  32   multiplier (two's complement)
//   mult_x    out 32   registered operand to the multiplier inX
//   mult_y    out 32   registered operand to the multiplier inY
//   prod_hi   in  32   multiplier outProductHigh
//   prod_lo   in  32   multiplier outProductLow
//   hi_we     in   1   mthi write request
//   lo_we     in   1   mtlo write request
//   hilo_din  in  32   data for mthi/mtlo
//   rd_hi     in   1   mfhi request
//   rd_lo     in   1   mflo request
//   hi_out    out 32   HI register
//   lo_out    out 32   LO register
//   busy      out  1   multiply in flight (state == WAIT)
//   done      out  1   one-cycle registered pulse: HI/LO hold the new product
//   stall     out  1   combinational: busy & any request
// -----------------------------------------------------------------------------
module mul_hilo_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [31:0] op_x,
  input  logic [31:0] op_y,
  output logic [31:0] mult_x,
  output logic [31:0] mult_y,
  input  logic [31:0] prod_hi,
  input  logic [31:0] prod_lo,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_din,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [31:0]   r_mult_x;
  logic [31:0]   w_mult_x_next;
  logic [31:0]   r_mult_y;
  logic [31:0]   w_mult_y_next;
  logic [31:0]   r_hi;
  logic [31:0]   w_hi_next;
  logic [31:0]   r_lo;
  logic [31:0]   w_lo_next;
  logic          r_done;
  logic          w_done_next;
  logic          w_any_req;

`ifdef MUL_HILO_ZERO_SKIP_EN
  logic w_zero_op;
  assign w_zero_op = (op_x == 32'd0) || (op_y == 32'd0);
`endif

  // State register. Reset discards any in-flight multiply.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mult_x <= '0;
      r_mult_y <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_mult_x <= w_mult_x_next;
      r_mult_y <= w_mult_y_next;
      r_hi     <= w_hi_next;
      r_lo     <= w_lo_next;
      r_done   <= w_done_next;
    end
  end

  // Next-state logic. Operands only change on an accepted start, so they
  // stay frozen across the whole WAIT window.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_mult_x_next = r_mult_x;
    w_mult_y_next = r_mult_y;
    w_hi_next     = r_hi;
    w_lo_next     = r_lo;
    w_done_next   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // mthi/mtlo land at this edge even if a start is accepted alongside;
        // the product overwrites them when the multiply completes.
        if (hi_we) begin
          w_hi_next = hilo_din;
        end
        if (lo_we) begin
          w_lo_next = hilo_din;
        end
        if (start) begin
          w_mult_x_next = op_x;
          w_mult_y_next = op_y;
`ifdef MUL_HILO_ZERO_SKIP_EN
          if (w_zero_op) begin
            // Known-zero product: the cleared HI/LO take precedence over
            // a same-cycle mthi/mtlo.
            w_hi_next   = 32'd0;
            w_lo_next   = 32'd0;
            w_done_next = 1'b1;
          end else begin
            w_cnt_next   = CW'(LATENCY - 1);
            w_state_next = S_WAIT;
          end
`else
          w_cnt_next   = CW'(LATENCY - 1);
          w_state_next = S_WAIT;
`endif
        end
      end

      S_WAIT: begin
        // Requests are ignored here; stall tells the requester to hold them.
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          // Final cycle of the window: the product has settled.
          w_hi_next    = prod_hi;
          w_lo_next    = prod_lo;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_any_req = start | rd_hi | rd_lo | hi_we | lo_we;

  assign mult_x = r_mult_x;
  assign mult_y = r_mult_y;
  assign hi_out = r_hi;
  assign lo_out = r_lo;
  assign busy   = (r_state == S_WAIT);
  assign done   = r_done;
  assign stall  = busy & w_any_req;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
module tb_mul_hilo_ctrl;

  localparam int LAT = 4;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic [31:0] op_x;
  logic [31:0] op_y;
  logic [31:0] mult_x;
  logic [31:0] mult_y;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_din;
  logic        rd_hi;
  logic        rd_lo;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  mul_hilo_ctrl #(.LATENCY(LAT)) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .start    (start),
    .op_x     (op_x),
    .op_y     (op_y),
    .mult_x   (mult_x),
    .mult_y   (mult_y),
    .prod_hi  (prod_hi),
    .prod_lo  (prod_lo),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hilo_din (hilo_din),
    .rd_hi    (rd_hi),
    .rd_lo    (rd_lo),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .stall    (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Signed 32x32 -> 64 product.
  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Bench multiplier: combinational product of the registered operands.
  logic [63:0] w_prod;
  assign w_prod  = smul(mult_x, mult_y);
  assign prod_hi = w_prod[63:32];
  assign prod_lo = w_prod[31:0];

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model in cycle-number terms: a multiply started in cycle t0 is
  // in flight during t0+1..t0+LAT, and its result and done show in t0+LAT+1.
  bit          m_inflight;
  int          m_t0;
  int          m_done_at;
  logic [63:0] m_pend;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_mx;
  logic [31:0] m_my;

  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_inflight <= 1'b0;
      m_t0       <= 0;
      m_done_at  <= -1;
      m_pend     <= '0;
      m_hi       <= '0;
      m_lo       <= '0;
      m_mx       <= '0;
      m_my       <= '0;
    end else if (!m_inflight) begin
      if (hi_we) m_hi <= hilo_din;
      if (lo_we) m_lo <= hilo_din;
      if (start) begin
        m_mx <= op_x;
        m_my <= op_y;
`ifdef MUL_HILO_ZERO_SKIP_EN
        if (op_x == 32'd0 || op_y == 32'd0) begin
          m_hi      <= '0;
          m_lo      <= '0;
          m_done_at <= cyc + 1;
        end else begin
`else
        begin
`endif
          m_inflight <= 1'b1;
          m_t0       <= cyc;
          m_pend     <= smul(op_x, op_y);
        end
      end
    end else if (cyc == m_t0 + LAT) begin
      m_hi       <= m_pend[63:32];
      m_lo       <= m_pend[31:0];
      m_inflight <= 1'b0;
      m_done_at  <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clock) begin
    #2;
    if (chk_en) begin
      chk("busy",   64'(busy),   64'(m_inflight));
      chk("done",   64'(done),   64'(cyc == m_done_at));
      chk("stall",  64'(stall),  64'(m_inflight && (start || rd_hi || rd_lo || hi_we || lo_we)));
      chk("hi_out", 64'(hi_out), 64'(m_hi));
      chk("lo_out", 64'(lo_out), 64'(m_lo));
      chk("mult_x", 64'(mult_x), 64'(m_mx));
      chk("mult_y", 64'(mult_y), 64'(m_my));
      if (done) $display("done cyc=%0d hi=%h lo=%h", cyc, hi_out, lo_out);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      start = 0; hi_we = 0; lo_we = 0; rd_hi = 0; rd_lo = 0;
    end
  endtask

  initial begin
    clear_n = 0; start = 0; op_x = 0; op_y = 0;
    hi_we = 0; lo_we = 0; hilo_din = 0; rd_hi = 0; rd_lo = 0;

    // Reset state
    @(negedge clock);
    chk_en = 1;
    #2;
    chk("lit_rst_busy",  64'(busy),   0);
    chk("lit_rst_done",  64'(done),   0);
    chk("lit_rst_stall", 64'(stall),  0);
    chk("lit_rst_hi",    64'(hi_out), 0);
    chk("lit_rst_lo",    64'(lo_out), 0);
    chk("lit_rst_mx",    64'(mult_x), 0);
    @(negedge clock);
    clear_n = 1;
    idle(2);

    // Basic multiply 3 * -2 with rd_lo held from cycle 2, then back-to-back 7*6
    @(negedge clock); start = 1; op_x = 32'd3; op_y = 32'hFFFFFFFE;   // c0
    @(negedge clock); start = 0; #2;                                   // c1
    chk("lit_a_busy1", 64'(busy), 1);
    @(negedge clock); rd_lo = 1; #2;                                   // c2
    chk("lit_a_busy2", 64'(busy), 1);
    chk("lit_a_stall2", 64'(stall), 1);
    @(negedge clock); #2;                                              // c3
    chk("lit_a_stall3", 64'(stall), 1);
    @(negedge clock); #2;                                              // c4
    chk("lit_a_busy4", 64'(busy), 1);
    chk("lit_a_stall4", 64'(stall), 1);
    @(negedge clock); start = 1; op_x = 32'd7; op_y = 32'd6; #2;      // c5
    chk("lit_a_done5", 64'(done), 1);
    chk("lit_a_busy5", 64'(busy), 0);
    chk("lit_a_stall5", 64'(stall), 0);
    chk("lit_a_hi5", 64'(hi_out), 64'hFFFFFFFF);
    chk("lit_a_lo5", 64'(lo_out), 64'hFFFFFFFA);
    @(negedge clock); start = 0; rd_lo = 0; #2;                        // c6
    chk("lit_b_busy6", 64'(busy), 1);
    @(negedge clock); #2;                                              // c7
    @(negedge clock); #2;                                              // c8
    @(negedge clock); #2;                                              // c9
    chk("lit_b_busy9", 64'(busy), 1);
    @(negedge clock); #2;                                              // c10
    chk("lit_b_done10", 64'(done), 1);
    chk("lit_b_lo10", 64'(lo_out), 64'd42);
    chk("lit_b_hi10", 64'(hi_out), 64'd0);
    idle(2);

    // Write ordering: mthi in IDLE, then start, then mthi during WAIT
    @(negedge clock); hi_we = 1; hilo_din = 32'hDEADBEEF;              // d0
    @(negedge clock); hi_we = 0; start = 1; op_x = 32'h10000; op_y = 32'h10000; #2; // d1
    chk("lit_w_hi1", 64'(hi_out), 64'hDEADBEEF);
    @(negedge clock); start = 0; #2;                                   // d2
    @(negedge clock); hi_we = 1; hilo_din = 32'h11111111; #2;          // d3
    chk("lit_w_stall3", 64'(stall), 1);
    @(negedge clock); hi_we = 0; #2;                                   // d4
    chk("lit_w_hi4", 64'(hi_out), 64'hDEADBEEF);
    @(negedge clock); #2;                                              // d5
    chk("lit_w_hi5", 64'(hi_out), 64'hDEADBEEF);
    @(negedge clock); #2;                                              // d6
    chk("lit_w_done6", 64'(done), 1);
    chk("lit_w_hi6", 64'(hi_out), 64'h1);
    chk("lit_w_lo6", 64'(lo_out), 64'h0);
    idle(2);

    // Reset mid-multiply, then a fresh multiply 5 * -3
    @(negedge clock); start = 1; op_x = 32'd9; op_y = 32'd9;           // e0
    idle(2);                                                           // e1,e2
    @(negedge clock); clear_n = 0; #2;                                 // e3
    chk("lit_r_busy", 64'(busy), 0);
    chk("lit_r_done", 64'(done), 0);
    chk("lit_r_hi", 64'(hi_out), 0);
    chk("lit_r_lo", 64'(lo_out), 0);
    chk("lit_r_mx", 64'(mult_x), 0);
    @(negedge clock); clear_n = 1;
    idle(8);
    @(negedge clock); start = 1; op_x = 32'd5; op_y = 32'hFFFFFFFD;    // f0
    idle(4);                                                           // f1..f4
    @(negedge clock); #2;                                              // f5
    chk("lit_f_done", 64'(done), 1);
    chk("lit_f_hi", 64'(hi_out), 64'hFFFFFFFF);
    chk("lit_f_lo", 64'(lo_out), 64'hFFFFFFF1);
    idle(2);

    // Zero operand
    @(negedge clock); start = 1; op_x = 32'd0; op_y = 32'h1234;        // g0
    @(negedge clock); start = 0; #2;                                   // g1
`ifdef MUL_HILO_ZERO_SKIP_EN
    chk("lit_z_done1", 64'(done), 1);
    chk("lit_z_busy1", 64'(busy), 0);
    chk("lit_z_hi1", 64'(hi_out), 0);
    chk("lit_z_lo1", 64'(lo_out), 0);
    idle(4);
`else
    chk("lit_z_busy1", 64'(busy), 1);
    idle(3);                                                           // g2..g4
    @(negedge clock); #2;                                              // g5
    chk("lit_z_done5", 64'(done), 1);
    chk("lit_z_hi5", 64'(hi_out), 0);
    chk("lit_z_lo5", 64'(lo_out), 0);
`endif
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      clear_n  = ($urandom_range(0, 249) != 0);
      start    = ($urandom_range(0, 3) == 0);
      op_x     = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      op_y     = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      hi_we    = ($urandom_range(0, 7) == 0);
      lo_we    = ($urandom_range(0, 7) == 0);
      hilo_din = $urandom;
      rd_hi    = ($urandom_range(0, 3) == 0);
      rd_lo    = ($urandom_range(0, 3) == 0);
    end
    @(negedge clock); clear_n = 1;
    idle(LAT + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
